decode_stage: RTL and testbench

Decode-side pipeline stage between instruction fetch and the immediate extender / register file. Accepts fetched instruction words over a valid/ready handshake, buffers them in a two-entry skid buffer, and presents registered decode fields: the raw 25-bit immediate field (instr[31:7]), the 2-bit immediate format select, register indices and an opcode class. Its `imm` and `imm_src` outputs drive the immediate extender directly.

---
 rtl/decode_stage.sv | 151 +++++++++++++++
 tb/tb_decode_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: two-entry skid buffer between fetch and the immediate extender /
// register file. Opcode is decoded on buffer entry; presented fields come straight from flops.
module decode_stage #(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic [24:0]     imm,
   output logic [1:0]      imm_src,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [2:0]      op_class,
   output logic            illegal
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
      logic [1:0]      imm_src;
      logic [2:0]      op_class;
      logic            illegal;
   } entry_t;

   // Unsupported opcodes still flow through; they are only flagged.
   function automatic entry_t decode_entry(input logic [31:0] instr, input logic [PC_W-1:0] pc);
      entry_t e;
      e.pc       = pc;
      e.instr    = instr;
      e.imm_src  = 2'b00;
      e.op_class = 3'd0;
      e.illegal  = 1'b0;
      case (instr[6:0])
         7'b0110011: e.op_class = 3'd0;
         7'b0010011: e.op_class = 3'd1;
         7'b0000011: e.op_class = 3'd2;
         7'b0100011: begin
            e.op_class = 3'd3;
            e.imm_src  = 2'b01;
         end
         7'b1100011: begin
            e.op_class = 3'd4;
            e.imm_src  = 2'b10;
         end
         7'b1101111: begin
            e.op_class = 3'd5;
            e.imm_src  = 2'b11;
         end
         7'b1100111: e.op_class = 3'd6;
         7'b0110111,
         7'b0010111: e.op_class = 3'd7;
         default:    e.illegal  = 1'b1;
      endcase
      return e;
   endfunction

   state_e state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t in_entry_s;
   logic   in_fire_s;
   logic   out_fire_s;

   assign in_ready   = (state_q != ST_FULL) && !rst;
   assign out_valid  = (state_q != ST_EMPTY);
   assign in_fire_s  = in_valid && in_ready;
   assign out_fire_s = out_valid && out_ready;
   assign in_entry_s = decode_entry(in_instr, in_pc);

   // Buffer next-state; flush only empties, so presented fields keep their last value.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  main_d  = in_entry_s;
                  state_d = ST_ONE;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_fire_s && out_fire_s) begin
                  main_d  = in_entry_s;
                  state_d = ST_ONE;
               end else if (in_fire_s) begin
                  skid_d  = in_entry_s;
                  state_d = ST_FULL;
               end else if (out_fire_s) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_FULL: begin
               if (out_fire_s) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // State and entry registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign out_pc    = main_q.pc;
   assign out_instr = main_q.instr;
   assign imm       = main_q.instr[31:7];
   assign imm_src   = main_q.imm_src;
   assign rd        = main_q.instr[11:7];
   assign rs1       = main_q.instr[19:15];
   assign rs2       = main_q.instr[24:20];
   assign op_class  = main_q.op_class;
   assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage plus hand-written multi-cycle sequences.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = 32'd0;
   logic [31:0] in_pc = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [24:0] imm;
   logic [1:0]  imm_src;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  op_class;
   logic        illegal;

   int total = 0;
   int bad = 0;

   decode_stage #(.PC_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .imm(imm), .imm_src(imm_src), .rd(rd), .rs1(rs1), .rs2(rs2),
      .op_class(op_class), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [24:0] imm;
      logic [1:0]  src;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  cls;
      logic        ill;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] fields();
      return {18'd0, imm, imm_src, rd, rs1, rs2, op_class, illegal};
   endfunction

   vec_t vt[11];
   logic [31:0] bp[5];
   logic [31:0] rx[$];
   logic [31:0] cap;
   logic fin, fout;
   int idx;

   initial begin
      vt[0]  = '{32'h00500093, 25'h000A001, 2'b00, 5'd1,  5'd0, 5'd5, 3'd1, 1'b0};
      vt[1]  = '{32'h0020A423, 25'h0004148, 2'b01, 5'd8,  5'd1, 5'd2, 3'd3, 1'b0};
      vt[2]  = '{32'h00000463, 25'h0000008, 2'b10, 5'd8,  5'd0, 5'd0, 3'd4, 1'b0};
      vt[3]  = '{32'h008000EF, 25'h0010001, 2'b11, 5'd1,  5'd0, 5'd8, 3'd5, 1'b0};
      vt[4]  = '{32'h002081B3, 25'h0004103, 2'b00, 5'd3,  5'd1, 5'd2, 3'd0, 1'b0};
      vt[5]  = '{32'h00412283, 25'h0008245, 2'b00, 5'd5,  5'd2, 5'd4, 3'd2, 1'b0};
      vt[6]  = '{32'h00008067, 25'h0000100, 2'b00, 5'd0,  5'd1, 5'd0, 3'd6, 1'b0};
      vt[7]  = '{32'h12345537, 25'h02468AA, 2'b00, 5'd10, 5'd8, 5'd3, 3'd7, 1'b0};
      vt[8]  = '{32'h00000017, 25'h0000000, 2'b00, 5'd0,  5'd0, 5'd0, 3'd7, 1'b0};
      vt[9]  = '{32'h0000007F, 25'h0000000, 2'b00, 5'd0,  5'd0, 5'd0, 3'd0, 1'b1};
      vt[10] = '{32'h00500093, 25'h000A001, 2'b00, 5'd1,  5'd0, 5'd5, 3'd1, 1'b0};
      bp[0] = 32'h00100093; bp[1] = 32'h00200113; bp[2] = 32'h00300193;
      bp[3] = 32'h00400213; bp[4] = 32'h00500293;

      // Reset held two cycles.
      tick();
      tick();
      chk("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_fields", fields(), 64'd0);
      chk("rst_pc_instr", {out_pc, out_instr}, 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready_high", {63'd0, in_ready}, 64'd1);

      // Streaming decode table, one per cycle.
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         in_valid = 1'b1;
         in_instr = vt[i].instr;
         in_pc    = 32'h1000 + 32'(i * 4);
         tick();
         chk($sformatf("dec_valid_%0d", i), {63'd0, out_valid}, 64'd1);
         chk($sformatf("dec_fields_%0d", i), fields(),
             {18'd0, vt[i].imm, vt[i].src, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].cls, vt[i].ill});
         chk($sformatf("dec_pc_%0d", i), {32'd0, out_pc}, {32'd0, 32'h1000 + 32'(i * 4)});
      end
      in_valid = 1'b0;
      tick();
      chk("drain_empty", {63'd0, out_valid}, 64'd0);

      // Backpressure: out_ready low for cycles 1-4, five offered back to back.
      idx = 0;
      rx.delete();
      for (int c = 1; c <= 40 && rx.size() < 5; c++) begin
         in_valid  = (idx < 5);
         in_instr  = (idx < 5) ? bp[idx] : 32'd0;
         in_pc     = 32'h2000 + 32'(idx * 4);
         out_ready = (c > 4);
         fin  = in_valid && in_ready;
         fout = out_valid && out_ready;
         cap  = out_instr;
         tick();
         if (fin) idx++;
         if (fout) rx.push_back(cap);
         if (c == 2) chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
         if (c == 3 || c == 4) chk($sformatf("bp_hold_%0d", c), {32'd0, out_instr}, {32'd0, bp[0]});
         if (c == 4) chk("bp_accepted", 64'(idx), 64'd2);
      end
      in_valid = 1'b0;
      chk("bp_count", 64'(rx.size()), 64'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < rx.size()) chk($sformatf("bp_order_%0d", i), {32'd0, rx[i]}, {32'd0, bp[i]});
      end
      tick();
      chk("bp_empty", {63'd0, out_valid}, 64'd0);

      // Flush while FULL with a concurrent input offer.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00A00513;
      tick();
      in_instr  = 32'h00B00593;
      tick();
      chk("fl_full", {63'd0, in_ready}, 64'd0);
      flush    = 1'b1;
      in_instr = 32'h00C00613;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
      chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
      in_valid  = 1'b1;
      in_instr  = 32'h00D00693;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("fl_next_valid", {63'd0, out_valid}, 64'd1);
      chk("fl_next_instr", {32'd0, out_instr}, 64'h00D00693);
      tick();
      chk("fl_drained", {63'd0, out_valid}, 64'd0);

      // Reset while FULL.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h0000007F;
      in_pc     = 32'h3000;
      tick();
      in_instr  = 32'h00000463;
      tick();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("rf_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rf_fields", fields(), 64'd0);
      chk("rf_pc_instr", {out_pc, out_instr}, 64'd0);
      chk("rf_in_ready_low", {63'd0, in_ready}, 64'd0);
      rst = 1'b0;
      #1;
      chk("rf_in_ready_high", {63'd0, in_ready}, 64'd1);
      in_valid  = 1'b1;
      in_instr  = 32'h008000EF;
      in_pc     = 32'h4000;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("rf_dec_valid", {63'd0, out_valid}, 64'd1);
      chk("rf_dec_fields", fields(), {18'd0, 25'h0010001, 2'b11, 5'd1, 5'd0, 5'd8, 3'd5, 1'b0});
      chk("rf_dec_pc", {32'd0, out_pc}, 64'h4000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
